// File: rtl/config_ctrl_pkg.sv
// config_ctrl_pkg : shared opcodes, FSM encoding and default chain sizes -- rev 1.0
`default_nettype none

package config_ctrl_pkg;

  localparam int DEF_SIZESRSTAT = 88;
  localparam int DEF_SIZESRDYN  = 16;
  localparam int DEF_CNTW       = 7;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_PLOAD = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/config_shift_ctrl.sv
// config_shift_ctrl : drives a downstream serial configuration register with
// write, non-destructive read and parallel-load commands -- rev 1.0
`default_nettype none

module config_shift_ctrl
  import config_ctrl_pkg::*;
#(
  parameter int SIZESRSTAT = DEF_SIZESRSTAT,
  parameter int SIZESRDYN  = DEF_SIZESRDYN,
  parameter int CNTW       = DEF_CNTW
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [1:0]            CMD_OP,
  input  logic                  CMD_TGT,
  input  logic [SIZESRSTAT-1:0] CMD_DATA,
  output logic                  SELDYN,
  output logic                  SELSTAT,
  output logic                  SDI,
  output logic                  PLOAD,
  input  logic                  SDO_IN,
  output logic [SIZESRSTAT-1:0] RB_DATA,
  output logic                  RB_VALID
);

  localparam logic [CNTW-1:0] c_dyn_last  = CNTW'(SIZESRDYN - 1);
  localparam logic [CNTW-1:0] c_stat_last = CNTW'(SIZESRSTAT - 1);

  state_e                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic                    tgt_q, tgt_d;
  logic [SIZESRSTAT-1:0]   data_q, data_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [SIZESRSTAT-1:0]   cap_q, cap_d;
  logic [SIZESRSTAT-1:0]   rb_data_q, rb_data_d;
  logic                    rb_valid_q, rb_valid_d;
  logic                    sel_dyn_q, sel_dyn_d;
  logic                    sel_stat_q, sel_stat_d;
  logic                    pload_q, pload_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tgt_d      = tgt_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    sel_dyn_d  = 1'b0;
    sel_stat_d = 1'b0;
    pload_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          op_d  = CMD_OP;
          tgt_d = CMD_TGT;
          cap_d = '0;
          cnt_d = CMD_TGT ? c_stat_last : c_dyn_last;
          // Dynamic payload is left-aligned so the shifter always serialises from the top bit.
          data_d = CMD_TGT ? CMD_DATA : (CMD_DATA << (SIZESRSTAT - SIZESRDYN));
          case (CMD_OP)
            OP_WRITE, OP_READ: begin
              state_d    = ST_SHIFT;
              sel_dyn_d  = ~CMD_TGT;
              sel_stat_d = CMD_TGT;
            end
            OP_PLOAD: begin
              state_d = ST_LOAD;
              pload_d = 1'b1;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_SHIFT: begin
        cap_d  = {cap_q[SIZESRSTAT-2:0], SDO_IN};
        data_d = data_q << 1;
        if (cnt_q == '0) begin
          state_d    = ST_DONE;
          rb_data_d  = cap_d;
          rb_valid_d = 1'b1;
        end else begin
          cnt_d      = cnt_q - CNTW'(1);
          sel_dyn_d  = ~tgt_q;
          sel_stat_d = tgt_q;
        end
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_WRITE;
      tgt_q      <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      cap_q      <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      sel_dyn_q  <= 1'b0;
      sel_stat_q <= 1'b0;
      pload_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tgt_q      <= tgt_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
      sel_dyn_q  <= sel_dyn_d;
      sel_stat_q <= sel_stat_d;
      pload_q    <= pload_d;
    end
  end

  // Read loops the returned bit straight back in so the chain rotates to its original value.
  always_comb begin
    SDI = 1'b0;
    if (sel_dyn_q || sel_stat_q) begin
      SDI = (op_q == OP_READ) ? SDO_IN : data_q[SIZESRSTAT-1];
    end
  end

  assign CMD_READY = (state_q == ST_IDLE);
  assign SELDYN    = sel_dyn_q;
  assign SELSTAT   = sel_stat_q;
  assign PLOAD     = pload_q;
  assign RB_DATA   = rb_data_q;
  assign RB_VALID  = rb_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_config_shift_ctrl.sv
// tb_config_shift_ctrl : directed bench with downstream chain model and readback scoreboard
`default_nettype none

module tb_config_shift_ctrl;

  localparam int NS = 88;
  localparam int ND = 16;

  logic          CLK;
  logic          RST_N;
  logic          CMD_VALID;
  logic          CMD_READY;
  logic [1:0]    CMD_OP;
  logic          CMD_TGT;
  logic [NS-1:0] CMD_DATA;
  logic          SELDYN;
  logic          SELSTAT;
  logic          SDI;
  logic          PLOAD;
  logic          SDO_IN;
  logic [NS-1:0] RB_DATA;
  logic          RB_VALID;

  int n_vec = 0;
  int n_bad = 0;
  logic [NS-1:0] sb_q[$];

  // downstream configuration registers
  logic [ND-1:0] dyn_chain  = 16'h4000;
  logic [NS-1:0] stat_chain = 88'hDEADBEEF0123456789ABCD;

  config_shift_ctrl #(.SIZESRSTAT(NS), .SIZESRDYN(ND), .CNTW(7)) dut (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_TGT(CMD_TGT), .CMD_DATA(CMD_DATA),
    .SELDYN(SELDYN), .SELSTAT(SELSTAT), .SDI(SDI), .PLOAD(PLOAD),
    .SDO_IN(SDO_IN), .RB_DATA(RB_DATA), .RB_VALID(RB_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign SDO_IN = SELSTAT ? stat_chain[NS-1] : dyn_chain[ND-1];

  always @(posedge CLK) begin
    if (SELDYN)  dyn_chain  <= {dyn_chain[ND-2:0], SDI};
    if (SELSTAT) stat_chain <= {stat_chain[NS-2:0], SDI};
  end

  task automatic chk(input string tag, input logic [NS-1:0] obs, input logic [NS-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_rb(input string tag);
    chk({tag, "_sb_nonempty"}, NS'(sb_q.size() > 0), NS'(1));
    if (sb_q.size() > 0) chk({tag, "_rbdata"}, RB_DATA, sb_q.pop_front());
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic tgt, input logic [NS-1:0] data,
                         input logic [NS-1:0] exp_rb, input string tag);
    int n, cycles, exp_low, sel_d, sel_s, both, pl, rbv, rb_cyc, low, idle_bad, mirror_bad, rb_moved;
    logic [NS-1:0] sdi_word, rb_before, exp_sdi;
    logic shift_op;
    shift_op = (op == 2'b00) || (op == 2'b01);
    n = tgt ? NS : ND;
    sel_d = 0; sel_s = 0; both = 0; pl = 0; rbv = 0; rb_cyc = -1; low = 0;
    idle_bad = 0; mirror_bad = 0; rb_moved = 0; sdi_word = '0;
    @(negedge CLK);
    chk({tag, "_ready"}, NS'(CMD_READY), NS'(1));
    rb_before = RB_DATA;
    CMD_VALID = 1'b1; CMD_OP = op; CMD_TGT = tgt; CMD_DATA = data;
    if (shift_op) sb_q.push_back(exp_rb);
    @(posedge CLK);
    #1 CMD_VALID = 1'b0; CMD_DATA = '0;
    cycles  = shift_op ? n + 2 : 3;
    exp_low = shift_op ? n + 1 : ((op == 2'b10) ? 1 : 0);
    for (int c = 1; c <= cycles; c++) begin
      @(negedge CLK);
      if (!CMD_READY) low++;
      if (SELDYN) sel_d++;
      if (SELSTAT) sel_s++;
      if (SELDYN && SELSTAT) both++;
      if (PLOAD) pl++;
      if (SELDYN || SELSTAT) begin
        sdi_word = {sdi_word[NS-2:0], SDI};
        if (SDI !== SDO_IN) mirror_bad++;
      end else if (SDI !== 1'b0) idle_bad++;
      if (RB_VALID) begin
        rbv++;
        rb_cyc = c;
        pop_rb(tag);
      end else if (rbv == 0 && RB_DATA !== rb_before) rb_moved++;
    end
    chk({tag, "_ready_low"}, NS'(low), NS'(exp_low));
    chk({tag, "_seldyn_cnt"}, NS'(sel_d), NS'((shift_op && !tgt) ? n : 0));
    chk({tag, "_selstat_cnt"}, NS'(sel_s), NS'((shift_op && tgt) ? n : 0));
    chk({tag, "_sel_both"}, NS'(both), NS'(0));
    chk({tag, "_pload_cnt"}, NS'(pl), NS'((op == 2'b10) ? 1 : 0));
    chk({tag, "_rbvalid_cnt"}, NS'(rbv), NS'(shift_op ? 1 : 0));
    chk({tag, "_sdi_idle"}, NS'(idle_bad), NS'(0));
    chk({tag, "_rb_stable"}, NS'(rb_moved), NS'(0));
    if (shift_op) chk({tag, "_latency"}, NS'(rb_cyc), NS'(n + 1));
    else chk({tag, "_rb_hold"}, RB_DATA, rb_before);
    if (op == 2'b00) begin
      exp_sdi = tgt ? data : {{(NS-ND){1'b0}}, data[ND-1:0]};
      chk({tag, "_sdi_bits"}, sdi_word, exp_sdi);
    end
    if (op == 2'b01) chk({tag, "_sdi_mirror"}, NS'(mirror_bad), NS'(0));
  endtask

  initial begin
    int low, rb_at, rbv, sel;
    bit done;
    RST_N = 1'b0; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_TGT = 1'b0; CMD_DATA = '0;
    repeat (2) @(negedge CLK);
    chk("rst_sel", NS'({SELDYN, SELSTAT}), NS'(0));
    chk("rst_sdi_pload", NS'({SDI, PLOAD}), NS'(0));
    chk("rst_rb", RB_DATA, '0);
    chk("rst_rbvalid", NS'(RB_VALID), NS'(0));
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_ready", NS'(CMD_READY), NS'(1));

    run_cmd(2'b00, 1'b0, 88'hA5C3, 88'h4000, "wr_dyn");
    chk("wr_dyn_chain", NS'(dyn_chain), NS'(16'hA5C3));
    run_cmd(2'b01, 1'b0, '0, 88'hA5C3, "rd_dyn");
    chk("rd_dyn_chain", NS'(dyn_chain), NS'(16'hA5C3));
    run_cmd(2'b00, 1'b1, 88'h1, 88'hDEADBEEF0123456789ABCD, "wr_stat");
    chk("wr_stat_chain", stat_chain, 88'h1);
    run_cmd(2'b01, 1'b1, '0, 88'h1, "rd_stat");
    chk("rd_stat_chain", stat_chain, 88'h1);
    run_cmd(2'b10, 1'b0, '0, '0, "pload");
    run_cmd(2'b11, 1'b1, 88'h55, '0, "rsvd");

    // held CMD_VALID across a dynamic write; upper payload bits must be ignored
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_OP = 2'b00; CMD_TGT = 1'b0; CMD_DATA = {{(NS-ND){1'b1}}, 16'h1234};
    sb_q.push_back(88'hA5C3);
    sb_q.push_back(88'h1234);
    @(posedge CLK);
    low = 0; rb_at = -1; done = 1'b0;
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge CLK);
      if (RB_VALID) begin
        rb_at = c;
        pop_rb("held1");
      end
      if (CMD_READY) done = 1'b1;
      else low++;
    end
    chk("held_ready_back", NS'(done), NS'(1));
    chk("held_ready_low", NS'(low), NS'(ND + 1));
    chk("held_rb_at", NS'(rb_at), NS'(ND + 1));
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
    @(negedge CLK);
    chk("held_second_accept", NS'(SELDYN), NS'(1));
    rbv = 0;
    for (int c = 0; c < 40 && rbv == 0; c++) begin
      @(negedge CLK);
      if (RB_VALID) begin
        rbv++;
        pop_rb("held2");
      end
    end
    chk("held2_rbvalid", NS'(rbv), NS'(1));
    chk("held_chain", NS'(dyn_chain), NS'(16'h1234));

    // reset in the middle of a static write
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_OP = 2'b00; CMD_TGT = 1'b1; CMD_DATA = 88'hF0F0F0F0F0F0F0F0F0F0F0;
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    chk("abort_selstat_before", NS'(SELSTAT), NS'(1));
    #1 RST_N = 1'b0;
    #1;
    chk("abort_sel", NS'({SELDYN, SELSTAT}), NS'(0));
    chk("abort_sdi_pload", NS'({SDI, PLOAD}), NS'(0));
    chk("abort_rb", RB_DATA, '0);
    chk("abort_rbvalid", NS'(RB_VALID), NS'(0));
    chk("abort_ready", NS'(CMD_READY), NS'(1));
    @(negedge CLK);
    RST_N = 1'b1;
    rbv = 0; sel = 0;
    repeat (100) begin
      @(negedge CLK);
      if (RB_VALID) rbv++;
      if (SELDYN || SELSTAT) sel++;
    end
    chk("abort_no_rbvalid", NS'(rbv), NS'(0));
    chk("abort_no_resume", NS'(sel), NS'(0));
    run_cmd(2'b01, 1'b0, '0, 88'h1234, "rd_after_rst");
    chk("sb_drained", NS'(sb_q.size()), NS'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
